vscale_dmem_bridge: RTL and testbench
=====================================

VSCALE_DMEM_BRIDGE -- requirements
Module: vscale_dmem_bridge

Interface
REQ-001 SHALL have one clock and one reset: the clock is clk, and the reset is asynchronous and active-low, named reset_n.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: dmem_en  in  1  pipeline address-phase valid.
REQ-005 SHALL have ports: dmem_wen  in  1  address phase is a store.
REQ-006 SHALL have ports: dmem_size  in  3  memory type; bits [1:0] select the size (0 byte, 1 half, 2 word, 3 illegal).
REQ-007 SHALL have ports: dmem_addr  in  32  byte address.
REQ-008 SHALL have ports: dmem_wdata_delayed  in  32  store data, valid and stable in data-phase cycles.
REQ-009 SHALL have ports: dmem_wait  out  1  stall request to pipeline.
REQ-010 SHALL have ports: dmem_rdata  out  32  raw aligned load word.
REQ-011 SHALL have ports: dmem_badmem_e  out  1  access fault.
REQ-012 SHALL have ports: bus_req  out  1  bus request, held until ack.
REQ-013 SHALL have ports: bus_we  out  1  bus write.
REQ-014 SHALL have ports: bus_addr  out  32  word address, bits [1:0] = 0.
REQ-015 SHALL have ports: bus_be  out  4  byte enables.
REQ-016 SHALL have ports: bus_wdata  out  32  write data.
REQ-017 SHALL have ports: bus_ack  in  1  single-cycle completion.
REQ-018 SHALL have ports: bus_rdata  in  32  read data, valid with ack.
REQ-019 SHALL have ports: bus_err  in  1  bus fault, valid with ack.

Function
REQ-020 SHALL accept an address phase when dmem_en=1 and dmem_wait=0, capturing wen, size[1:0], addr and a misaligned flag (half: addr[0]; word: |addr[1:0]; size 3: always).
REQ-021 SHALL implement FSM states IDLE, DATA, BUS, RESP.
REQ-022 SHALL transition from IDLE or RESP to DATA on an accepted address phase, and otherwise to IDLE.
REQ-023 SHALL, in DATA, assert dmem_wait=1 and register bus_wdata<=dmem_wdata_delayed; the next state is RESP if the access is misaligned, else BUS.
REQ-024 SHALL, in BUS, assert bus_req=1 and dmem_wait=1, with bus_we, bus_addr={addr[31:2],2'b00} and bus_be held stable until bus_ack; on bus_ack the next state is RESP.
REQ-025 SHALL drive bus_be as 4'b0001<<addr[1:0] for byte accesses, as 4'b1100 (addr[1]=1) or 4'b0011 (addr[1]=0) for half accesses, and as 4'b1111 for word accesses.
REQ-026 SHALL register dmem_rdata<=bus_rdata on an ack for a load, and keep dmem_rdata unchanged on stores and on faults.
REQ-027 SHALL, in RESP, drive dmem_wait=0 for exactly one cycle, with dmem_badmem_e=1 iff the access was misaligned or bus_err was sampled with bus_ack.
REQ-028 SHALL drive dmem_badmem_e=0 in all states other than RESP.
REQ-029 SHALL drive dmem_wait=0 in IDLE.
REQ-030 SHALL never issue a bus request for a misaligned access.
REQ-031 SHALL give an aligned access a dmem_wait-high duration of 1+N cycles, where N is the number of BUS cycles up to and including ack (N>=1).
REQ-032 SHALL give a misaligned access exactly 1 wait cycle.
REQ-033 SHALL support back-to-back accesses: an address phase accepted in a RESP cycle enters DATA with no idle bubble.
REQ-034 SHALL ignore bus_ack outside BUS.
REQ-035 SHALL ignore dmem_en while dmem_wait=1.
REQ-036 SHALL drive bus_req as a decode of the state register only, with no combinational path from bus_ack.

Reset
REQ-037 SHALL, while reset_n=0, immediately force the state to IDLE and force bus_req, dmem_wait, dmem_badmem_e, bus_we and bus_be to 0, and bus_addr, bus_wdata and dmem_rdata to 32'h0.
REQ-038 SHALL drop bus_req asynchronously on a reset during BUS, discarding the outstanding access; a later bus_ack is ignored.
REQ-039 SHALL resume normal acceptance on the first rising clk edge after reset_n deasserts.

Verification
REQ-040 SHALL cover a word load: LW at addr 0x100, bus_ack after 2 BUS cycles with rdata 0xDEADBEEF -> bus_addr=0x100, bus_be=1111, dmem_wait high 3 cycles, RESP shows dmem_rdata=0xDEADBEEF and badmem=0.
REQ-041 SHALL cover a byte store: SB at addr 0x203 with wdata_delayed 0x5A5A5A5A, immediate ack -> bus_we=1, bus_addr=0x200, bus_be=1000, bus_wdata=0x5A5A5A5A, dmem_wait high 2 cycles.
REQ-042 SHALL cover a misaligned access: LW at 0x102 -> bus_req never asserts, dmem_wait high 1 cycle, badmem=1 in RESP, dmem_rdata unchanged.
REQ-043 SHALL cover a bus fault: SH at 0x40 with ack+err -> bus_be=0011, badmem=1 in RESP only.
REQ-044 SHALL cover back-to-back access: LW 0x0 then SW 0x4 presented in the RESP cycle -> second DATA begins the next cycle with no IDLE cycle between.
REQ-045 SHALL cover reset mid-operation: reset_n low during BUS -> bus_req and dmem_wait are 0 in the same cycle; an ack arriving after release is ignored and the FSM stays in IDLE.

Source files
------------

// File: rtl/vscale_dmem_bridge.sv
// ---------------------------------------------------------------------------
// vscale_dmem_bridge
//   Turns the V-scale pipeline's split address/data-phase data-memory port into
//   a simple request/ack bus transaction. Accesses are handled one at a time.
//   A misaligned access never reaches the bus. It is answered as an access
//   fault after a single wait cycle.
//
//   Pipeline side:
//     dmem_en, dmem_wen, dmem_size, dmem_addr  address phase (taken when !dmem_wait)
//     dmem_wdata_delayed                       store data, valid in the data phase
//     dmem_wait                                stall request back to the pipeline
//     dmem_rdata                               last loaded word (raw, aligned)
//     dmem_badmem_e                            access fault, valid in the response cycle
//   Bus side:
//     bus_req, bus_we, bus_addr, bus_be, bus_wdata   request, held until bus_ack
//     bus_ack, bus_rdata, bus_err                    single-cycle completion
//
//   FSM: IDLE -> DATA -> BUS (N cycles) -> RESP. A misaligned access goes
//   DATA -> RESP. A new access can be accepted in RESP with no IDLE bubble.
// ---------------------------------------------------------------------------
module vscale_dmem_bridge (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dmem_en,
    input  logic        dmem_wen,
    input  logic [2:0]  dmem_size,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata_delayed,
    output logic        dmem_wait,
    output logic [31:0] dmem_rdata,
    output logic        dmem_badmem_e,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    typedef enum logic [1:0] {IDLE, DATA, BUS, RESP} state_e;

    state_e      state_q;
    logic        misal_q;     // captured misalignment of the current access
    logic        fault_q;     // response of the current access is a fault
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        misal_d;
    logic [3:0]  be_d;

    // dmem_size[2] is the unsigned-load flag. Sign handling is done by the
    // pipeline on the raw word, so this block does not need it.
    logic        unused_size_hi;
    assign unused_size_hi = dmem_size[2];

    // Only the wait-free states (IDLE, RESP) can take an address phase. Any
    // dmem_en raised while dmem_wait is high is therefore ignored.
    assign accept = dmem_en && !dmem_wait;

    always_comb begin
        misal_d = 1'b0;
        be_d    = 4'b0000;
        unique case (dmem_size[1:0])
            2'd0: begin
                be_d = 4'b0001 << dmem_addr[1:0];
            end
            2'd1: begin
                misal_d = dmem_addr[0];
                be_d    = dmem_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                misal_d = |dmem_addr[1:0];
                be_d    = 4'b1111;
            end
            default: begin
                misal_d = 1'b1;    // illegal size: always faulted, never issued
            end
        endcase
    end

    // Handshake outputs are pure decodes of the state register. As a result,
    // bus_req has no combinational path from bus_ack. A reset during BUS drops
    // bus_req the moment the state register clears.
    assign dmem_wait     = (state_q == DATA) || (state_q == BUS);
    assign bus_req       = (state_q == BUS);
    assign dmem_badmem_e = (state_q == RESP) && fault_q;

    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;
    assign dmem_rdata = rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            misal_q     <= 1'b0;
            fault_q     <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
        end else begin
            unique case (state_q)
                IDLE, RESP: begin
                    if (accept) begin
                        state_q    <= DATA;
                        misal_q    <= misal_d;
                        fault_q    <= 1'b0;
                        bus_we_q   <= dmem_wen;
                        bus_addr_q <= {dmem_addr[31:2], 2'b00};
                        bus_be_q   <= be_d;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    bus_wdata_q <= dmem_wdata_delayed;
                    if (misal_q) begin
                        fault_q <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        state_q <= BUS;
                    end
                end
                BUS: begin
                    if (bus_ack) begin
                        state_q <= RESP;
                        if (bus_err) begin
                            fault_q <= 1'b1;       // load data is not updated on a fault
                        end else if (!bus_we_q) begin
                            rdata_q <= bus_rdata;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
module tb_vscale_dmem_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dmem_en, dmem_wen;
    logic [2:0]  dmem_size;
    logic [31:0] dmem_addr, dmem_wdata_delayed;
    logic        dmem_wait, dmem_badmem_e;
    logic [31:0] dmem_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack, bus_err;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    // Results of the most recent access, filled in by do_access.
    int          waits, reqcnt;
    logic        bad_early;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;

    always #5 clk = ~clk;

    vscale_dmem_bridge dut (
        .clk(clk), .reset_n(reset_n),
        .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size),
        .dmem_addr(dmem_addr), .dmem_wdata_delayed(dmem_wdata_delayed),
        .dmem_wait(dmem_wait), .dmem_rdata(dmem_rdata), .dmem_badmem_e(dmem_badmem_e),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The task is called just after an edge, in a cycle where dmem_wait is 0.
    // It presents one access and acks it on the n-th BUS cycle. During the
    // wait cycles it drives a junk address phase, which the DUT must ignore.
    // The task returns while the DUT is in the RESP cycle.
    task automatic do_access(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input int n, input logic err,
                             input logic [31:0] rdata);
        waits = 0; reqcnt = 0; bad_early = 1'b0;
        r_we = 1'b0; r_addr = 32'h0; r_wdata = 32'h0; r_be = 4'h0;
        dmem_en = 1'b1; dmem_wen = wen; dmem_size = size; dmem_addr = addr;
        dmem_wdata_delayed = wdata;
        tick();
        dmem_en = 1'b1; dmem_wen = 1'b1; dmem_size = 3'd2; dmem_addr = 32'hFFC;
        for (int k = 0; k < 20; k++) begin
            if (!dmem_wait) break;
            waits++;
            bad_early |= dmem_badmem_e;
            if (bus_req) begin
                reqcnt++;
                r_we = bus_we; r_addr = bus_addr; r_be = bus_be; r_wdata = bus_wdata;
                bus_ack = (reqcnt == n);
                bus_err = err;
                bus_rdata = rdata;
            end else begin
                bus_ack = 1'b0;
            end
            tick();
        end
        chk("timeout", {31'h0, dmem_wait}, 32'h0);
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
        dmem_en = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        dmem_en = 1'b0; dmem_wen = 1'b0; dmem_size = 3'd0; dmem_addr = 32'h0;
        dmem_wdata_delayed = 32'h0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
        #12;
        chk("rst_wait", {31'h0, dmem_wait}, 32'h0);
        chk("rst_req", {31'h0, bus_req}, 32'h0);
        chk("rst_bad", {31'h0, dmem_badmem_e}, 32'h0);
        chk("rst_be_we", {27'h0, bus_we, bus_be}, 32'h0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_rdata", dmem_rdata, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // LW 0x100, ack on the 2nd BUS cycle
        do_access(1'b0, 3'd2, 32'h100, 32'h0, 2, 1'b0, 32'hDEADBEEF);
        chk("lw_waits", waits, 3);
        chk("lw_reqs", reqcnt, 2);
        chk("lw_addr", r_addr, 32'h100);
        chk("lw_be", {28'h0, r_be}, 32'hF);
        chk("lw_we", {31'h0, r_we}, 32'h0);
        chk("lw_bad", {31'h0, dmem_badmem_e}, 32'h0);
        chk("lw_rdata", dmem_rdata, 32'hDEADBEEF);
        chk("lw_bad_early", {31'h0, bad_early}, 32'h0);
        tick();
        chk("lw_idle_wait", {31'h0, dmem_wait}, 32'h0);

        // SB 0x203, immediate ack
        do_access(1'b1, 3'd0, 32'h203, 32'h5A5A5A5A, 1, 1'b0, 32'h12345678);
        chk("sb_waits", waits, 2);
        chk("sb_we", {31'h0, r_we}, 32'h1);
        chk("sb_addr", r_addr, 32'h200);
        chk("sb_be", {28'h0, r_be}, 32'h8);
        chk("sb_wdata", r_wdata, 32'h5A5A5A5A);
        chk("sb_rdata_kept", dmem_rdata, 32'hDEADBEEF);
        chk("sb_bad", {31'h0, dmem_badmem_e}, 32'h0);
        tick();

        // Misaligned LW 0x102: no bus request, one wait cycle, fault
        do_access(1'b0, 3'd2, 32'h102, 32'h0, 1, 1'b0, 32'h0);
        chk("mis_reqs", reqcnt, 0);
        chk("mis_waits", waits, 1);
        chk("mis_bad", {31'h0, dmem_badmem_e}, 32'h1);
        chk("mis_rdata", dmem_rdata, 32'hDEADBEEF);
        chk("mis_bad_early", {31'h0, bad_early}, 32'h0);
        tick();
        chk("mis_bad_after", {31'h0, dmem_badmem_e}, 32'h0);

        // Illegal size 3 is always treated as misaligned
        do_access(1'b0, 3'd3, 32'h0, 32'h0, 1, 1'b0, 32'h0);
        chk("sz3_reqs", reqcnt, 0);
        chk("sz3_bad", {31'h0, dmem_badmem_e}, 32'h1);
        tick();

        // SH 0x40 with a bus error
        do_access(1'b1, 3'd1, 32'h40, 32'h0000BEEF, 1, 1'b1, 32'h0);
        chk("sh_be", {28'h0, r_be}, 32'h3);
        chk("sh_waits", waits, 2);
        chk("sh_bad", {31'h0, dmem_badmem_e}, 32'h1);
        chk("sh_bad_early", {31'h0, bad_early}, 32'h0);
        tick();
        chk("sh_bad_after", {31'h0, dmem_badmem_e}, 32'h0);

        // LH 0x42 with error: upper half enables, load data not updated
        do_access(1'b0, 3'd5, 32'h42, 32'h0, 1, 1'b1, 32'h99999999);
        chk("lh_be", {28'h0, r_be}, 32'hC);
        chk("lh_rdata_kept", dmem_rdata, 32'hDEADBEEF);
        chk("lh_bad", {31'h0, dmem_badmem_e}, 32'h1);
        tick();

        // Back-to-back: LW 0x0, then SW 0x4 presented in the RESP cycle
        do_access(1'b0, 3'd2, 32'h0, 32'h0, 1, 1'b0, 32'h11223344);
        chk("b2b_lw_rdata", dmem_rdata, 32'h11223344);
        chk("b2b_lw_waits", waits, 2);
        do_access(1'b1, 3'd2, 32'h4, 32'hCAFEF00D, 1, 1'b0, 32'h0);
        chk("b2b_sw_waits", waits, 2);
        chk("b2b_sw_addr", r_addr, 32'h4);
        chk("b2b_sw_wdata", r_wdata, 32'hCAFEF00D);
        chk("b2b_sw_we", {31'h0, r_we}, 32'h1);
        tick();

        // Reset during BUS
        dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h300;
        tick();
        dmem_en = 1'b0;
        tick();
        chk("mid_req_before", {31'h0, bus_req}, 32'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_req_async", {31'h0, bus_req}, 32'h0);
        chk("mid_wait_async", {31'h0, dmem_wait}, 32'h0);
        chk("mid_rdata_clr", dmem_rdata, 32'h0);
        tick();
        reset_n = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'hBADBAD00;
        tick();
        bus_ack = 1'b0;
        chk("mid_stray_req", {31'h0, bus_req}, 32'h0);
        chk("mid_stray_wait", {31'h0, dmem_wait}, 32'h0);
        chk("mid_stray_rdata", dmem_rdata, 32'h0);
        tick();
        chk("mid_idle_wait", {31'h0, dmem_wait}, 32'h0);
        chk("mid_idle_bad", {31'h0, dmem_badmem_e}, 32'h0);

        // Normal operation resumes: LB 0x301
        do_access(1'b0, 3'd4, 32'h301, 32'h0, 1, 1'b0, 32'h0000AB00);
        chk("lb_be", {28'h0, r_be}, 32'h2);
        chk("lb_addr", r_addr, 32'h300);
        chk("lb_rdata", dmem_rdata, 32'h0000AB00);
        chk("lb_waits", waits, 2);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
